// File: rtl/led_trail_pwm.sv
// Per-LED PWM driver with a decaying "comet tail": a lit pattern bit drives full brightness,
// and a cleared bit fades its channel down in fixed steps on each fade tick.
module led_trail_pwm #(
  parameter int unsigned NUM_LED   = 8,
  parameter int unsigned PWM_BITS  = 8,
  parameter int unsigned FADE_DIV  = 250000,
  parameter int unsigned FADE_STEP = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [NUM_LED-1:0] pattern_in,
  output logic [NUM_LED-1:0] led_out,
  output logic               pwm_wrap
);

  localparam int unsigned DivW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [PWM_BITS-1:0] Max     = '1;
  localparam logic [PWM_BITS-1:0] Step    = PWM_BITS'(FADE_STEP);
  localparam logic [DivW-1:0]     DivLast = DivW'(FADE_DIV - 1);

  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [DivW-1:0]     div_cnt_q, div_cnt_d;
  logic [PWM_BITS-1:0] level_q [NUM_LED];
  logic [PWM_BITS-1:0] level_d [NUM_LED];
  logic [PWM_BITS-1:0] duty_q  [NUM_LED];
  logic [PWM_BITS-1:0] duty_d  [NUM_LED];
  logic [NUM_LED-1:0]  led_d;
  logic                wrap_d;
  logic                fade_tick;
  logic                period_end;

  assign fade_tick  = (div_cnt_q == DivLast);
  assign period_end = (pwm_cnt_q == Max);

  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 1'b1;
    div_cnt_d = fade_tick ? '0 : div_cnt_q + 1'b1;
    wrap_d    = period_end;
    led_d     = '0;
    for (int i = 0; i < NUM_LED; i++) begin
      level_d[i] = level_q[i];
      if (pattern_in[i]) begin
        level_d[i] = Max;
      end else if (fade_tick && (level_q[i] > Step)) begin
        level_d[i] = level_q[i] - Step;
      end else if (fade_tick) begin
        level_d[i] = '0;
      end
      // Shadow duty only reloads at the period boundary so a period is never cut short.
      duty_d[i] = period_end ? level_q[i] : duty_q[i];
      led_d[i]  = (duty_q[i] == Max) || (pwm_cnt_q < duty_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      pwm_cnt_q <= '0;
      div_cnt_q <= '0;
      led_out   <= '0;
      pwm_wrap  <= 1'b0;
      for (int i = 0; i < NUM_LED; i++) begin
        level_q[i] <= '0;
        duty_q[i]  <= '0;
      end
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      div_cnt_q <= div_cnt_d;
      led_out   <= led_d;
      pwm_wrap  <= wrap_d;
      for (int i = 0; i < NUM_LED; i++) begin
        level_q[i] <= level_d[i];
        duty_q[i]  <= duty_d[i];
      end
    end
  end

endmodule

// File: tb/tb_led_trail_pwm.sv
// Directed bench for led_trail_pwm: walks whole PWM periods with hand-derived per-channel duties.
module tb_led_trail_pwm;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [7:0] pattern_in;
  logic [7:0] led_out;
  logic       pwm_wrap;

  int checks;
  int failures;

  led_trail_pwm #(
    .NUM_LED  (8),
    .PWM_BITS (4),
    .FADE_DIV (4),
    .FADE_STEP(6)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .pattern_in(pattern_in),
    .led_out   (led_out),
    .pwm_wrap  (pwm_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_led(input string tag, input logic [7:0] exp);
    checks++;
    assert (led_out === exp) else begin
      failures++;
      $error("FAIL %s led_out=%h expected %h", tag, led_out, exp);
    end
  endtask

  task automatic chk_wrap(input string tag, input logic exp);
    checks++;
    assert (pwm_wrap === exp) else begin
      failures++;
      $error("FAIL %s pwm_wrap=%b expected %b", tag, pwm_wrap, exp);
    end
  endtask

  // Runs len edges of a period that starts with pwm_cnt==0. duty holds one nibble per channel.
  // Pattern changes to p1/p2 after edge c1/c2 of the block (0 = before the first edge).
  task automatic run_block(input string tag, input int len, input logic [31:0] duty,
                           input int c1, input logic [7:0] p1,
                           input int c2, input logic [7:0] p2);
    logic [7:0] exp;
    logic [3:0] d;
    logic [3:0] p;
    if (c1 == 0) pattern_in = p1;
    if (c2 == 0) pattern_in = p2;
    for (int j = 1; j <= len; j++) begin
      @(posedge clk);
      #1;
      p = 4'(j - 1);
      for (int i = 0; i < 8; i++) begin
        d = duty[4*i +: 4];
        exp[i] = (d == 4'hF) || (p < d);
      end
      chk_led(tag, exp);
      chk_wrap(tag, (p == 4'hF));
      if (j == c1) pattern_in = p1;
      if (j == c2) pattern_in = p2;
    end
  endtask

  task automatic idle_edges(input string tag, input int n);
    for (int j = 0; j < n; j++) begin
      @(posedge clk);
      #1;
      chk_led(tag, 8'h00);
      chk_wrap(tag, 1'b0);
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    enable     = 1'b1;
    pattern_in = 8'hFF;

    // Reset holds everything dark even with every pattern bit set.
    idle_edges("reset", 3);
    rst        = 1'b0;
    pattern_in = 8'h01;

    // First period shows duty 0; full-on channel 0 from the period after the first wrap.
    run_block("first_period", 16, 32'h0, -1, 8'h00, -1, 8'h00);
    run_block("ch0_full",     16, 32'hF, -1, 8'h00, -1, 8'h00);

    // Drop so the first tick lands 4 edges before the load: duty 9, then 0.
    run_block("drop_a",   16, 32'hF, 8, 8'h00, -1, 8'h00);
    run_block("duty9",    16, 32'h9, -1, 8'h00, -1, 8'h00);
    run_block("after9",   16, 32'h0, 0, 8'h01, -1, 8'h00);
    // Drop so two ticks land before the load: duty 3, then saturated at 0.
    run_block("drop_b",   16, 32'hF, 4, 8'h00, -1, 8'h00);
    run_block("duty3",    16, 32'h3, -1, 8'h00, -1, 8'h00);
    run_block("sat0",     16, 32'h0, -1, 8'h00, -1, 8'h00);

    // Pattern bit 3 high only on the tick edge: pattern must win, duty loads 15 not 9.
    run_block("tick_race",  16, 32'h0,    11, 8'h08, 12, 8'h00);
    run_block("race_duty",  16, 32'hF000, -1, 8'h00, -1, 8'h00);

    // Mid-period pattern changes take effect only at the next boundary.
    run_block("mid_a", 16, 32'h0,        5, 8'h81, -1, 8'h00);
    run_block("mid_b", 16, 32'hF000000F, 3, 8'h42, -1, 8'h00);
    run_block("mid_c", 6,  32'h0F0000F0, 2, 8'h00, -1, 8'h00);

    // Disable mid-fade: dark next edge, and re-enable starts a clean period.
    enable = 1'b0;
    idle_edges("disable", 3);
    pattern_in = 8'h10;
    enable     = 1'b1;
    run_block("reen_a", 16, 32'h0,     -1, 8'h00, -1, 8'h00);
    run_block("reen_b", 16, 32'h000F0000, -1, 8'h00, -1, 8'h00);
    run_block("reen_c", 5,  32'h000F0000, -1, 8'h00, -1, 8'h00);

    // Reset mid-period behaves the same way.
    rst = 1'b1;
    idle_edges("mid_reset", 2);
    rst        = 1'b0;
    pattern_in = 8'h00;
    run_block("post_reset", 16, 32'h0, -1, 8'h00, -1, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
